mul_mantissa: RTL and testbench

Sequential shift-and-add unsigned multiplier for the floating-point datapath. It forms the full 2×DATAWIDTH-bit product of two mantissas (hidden bit included) and is the multiply-side counterpart of the restoring mantissa divider. It shares the divider's `en`/`mode` start and `isdone` completion convention, so the FPU controller can dispatch to either unit the same way. Exponent, sign and rounding logic live outside this block.

---
 rtl/mul_mantissa_pkg.sv | 14 +
 rtl/mul_mantissa.sv | 85 ++++++++
 tb/tb_mul_mantissa.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mul_mantissa_pkg.sv
// Shared FPU constants: sequencer state encoding and operation mode codes.
package mul_mantissa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ADD   = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [2:0] MODE_MUL = 3'd2;
  localparam logic [2:0] MODE_DIV = 3'd3;

endpackage

// File: rtl/mul_mantissa.sv
// Sequential shift-and-add unsigned mantissa multiplier producing the full
// 2*DATAWIDTH-bit product, one ADD/SHIFT pair per multiplier bit.
module mul_mantissa
  import mul_mantissa_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic [DATAWIDTH-1:0]     multiplicand,
  input  logic [DATAWIDTH-1:0]     multiplier,
  output logic                     isdone,
  output logic [2*DATAWIDTH-1:0]   product,
  output logic                     ovf
);

  localparam int unsigned W  = DATAWIDTH;
  localparam int unsigned CW = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

  state_t          state;
  logic [2*W:0]    acc;
  logic [W-1:0]    mcand;
  logic [W-1:0]    mplier;
  logic [CW-1:0]   cnt;
  logic [W:0]      sum;

  // Upper half plus multiplicand; the extra bit keeps the carry.
  assign sum = (W+1)'({1'b0, acc[2*W-1:W]}) + (W+1)'({1'b0, mcand});

  assign ovf = product[2*W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      isdone  <= 1'b0;
    end else begin
      isdone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && (mode == MODE_MUL)) begin
            mcand  <= multiplicand;
            mplier <= multiplier;
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (mplier[0]) begin
            acc[2*W:W] <= sum;
          end
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          acc    <= acc >> 1;
          mplier <= mplier >> 1;
          if (cnt == CNT_LAST) begin
            // Capture the post-shift value so product is valid in DONE.
            product <= acc[2*W:1];
            isdone  <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= ST_ADD;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_mantissa.sv
// Directed self-checking bench for mul_mantissa at DATAWIDTH=24.
module tb_mul_mantissa;
  import mul_mantissa_pkg::*;

  localparam int unsigned W = 24;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [2:0]      mode;
  logic [W-1:0]    multiplicand;
  logic [W-1:0]    multiplier;
  logic            isdone;
  logic [2*W-1:0]  product;
  logic            ovf;

  int n_checks = 0;
  int n_fail   = 0;

  mul_mantissa #(.DATAWIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .isdone       (isdone),
    .product      (product),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start an operation in the current cycle (cycle 0) and watch it to cycle 55.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input logic exp_o);
    int            first_done;
    int            n_done;
    logic [2*W-1:0] p49;
    logic          o49;
    first_done = -1;
    n_done     = 0;
    p49        = '0;
    o49        = 1'b0;
    multiplicand = a;
    multiplier   = b;
    en           = 1'b1;
    mode         = MODE_MUL;
    for (int c = 1; c <= 55; c++) begin
      next_cycle();
      if (c == 1) begin
        en           = 1'b0;
        multiplicand = ~a;
        multiplier   = ~b;
      end
      if (isdone) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (c == 49) begin
        p49 = product;
        o49 = ovf;
      end
    end
    check({tag, "_done_cycle"}, 64'(first_done), 64'd49);
    check({tag, "_done_count"}, 64'(n_done), 64'd1);
    check({tag, "_product"}, 64'(p49), 64'(exp_p));
    check({tag, "_ovf"}, 64'(o49), 64'(exp_o));
    check({tag, "_product_hold"}, 64'(product), 64'(exp_p));
  endtask

  initial begin
    int n_done;
    int n_busy;

    rst          = 1'b1;
    en           = 1'b0;
    mode         = 3'd0;
    multiplicand = '0;
    multiplier   = '0;
    next_cycle();
    next_cycle();
    check("reset_isdone", 64'(isdone), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_state", 64'(dut.state), 64'(ST_IDLE));
    rst = 1'b0;
    next_cycle();

    run_op("basic", 24'h800000, 24'h800000, 48'h400000000000, 1'b0);
    run_op("zero_a", 24'h000000, 24'hC00000, 48'h0, 1'b0);
    run_op("zero_b", 24'hC00000, 24'h000000, 48'h0, 1'b0);
    run_op("max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 1'b1);

    // Divide-mode requests must be ignored entirely.
    n_done = 0;
    n_busy = 0;
    en     = 1'b1;
    mode   = MODE_DIV;
    for (int c = 0; c < 100; c++) begin
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      next_cycle();
      if (isdone) n_done++;
      if (dut.state != ST_IDLE) n_busy++;
    end
    en = 1'b0;
    check("filter_done_count", 64'(n_done), 64'd0);
    check("filter_busy_cycles", 64'(n_busy), 64'd0);
    check("filter_product", 64'(product), 64'hFFFFFE000001);
    check("filter_ovf", 64'(ovf), 64'd1);

    // Reset in cycle 10 of an operation.
    multiplicand = 24'hC00000;
    multiplier   = 24'hC00000;
    en           = 1'b1;
    mode         = MODE_MUL;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 1) en = 1'b0;
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("midrst_product", 64'(product), 64'd0);
    check("midrst_isdone", 64'(isdone), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_state", 64'(dut.state), 64'(ST_IDLE));
    next_cycle();
    run_op("restart", 24'hC00000, 24'hC00000, 48'h900000000000, 1'b1);

    // Back-to-back with en held and operands scrambled while busy.
    en   = 1'b1;
    mode = MODE_MUL;
    for (int c = 0; c <= 150; c++) begin
      if (c > 0) next_cycle();
      case (c)
        0:   begin multiplicand = 24'h000003; multiplier = 24'h000005; end
        50:  begin multiplicand = 24'h123456; multiplier = 24'h000010; end
        100: begin multiplicand = 24'h000FFF; multiplier = 24'h001001; end
        default: begin
          multiplicand = W'($urandom);
          multiplier   = W'($urandom);
        end
      endcase
      check($sformatf("b2b_isdone_c%0d", c), 64'(isdone),
            64'((c == 49) || (c == 99) || (c == 149)));
      if (c == 49)  check("b2b_product_0", 64'(product), 64'h00000000000F);
      if (c == 99)  check("b2b_product_1", 64'(product), 64'h000001234560);
      if (c == 149) begin
        check("b2b_product_2", 64'(product), 64'h000000FFFFFF);
        check("b2b_ovf_2", 64'(ovf), 64'd0);
      end
    end
    en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
